// File: rtl/apu_wave_pkg.sv
// Shared types and constants for the channel 3 wave pattern RAM.
// Pulled in by the array and by the top-level wrapper.
package apu_wave_pkg;
   localparam int WAVE_BYTES = 16;
   localparam int WAVE_AW    = 4;
   localparam int WIN_CNT_W  = 2;

   typedef logic [7:0] wave_byte_t;
   typedef logic [3:0] wave_nib_t;

   localparam wave_byte_t WAVE_CLOSED_RD = 8'hFF;

   localparam logic [WIN_CNT_W-1:0] WIN_LOAD = WIN_CNT_W'(1);
endpackage

// File: rtl/wave_ram_array.sv
// Wave pattern storage: one synchronous write port, two combinational read ports.
// There is no reset, so the contents survive an APU reset.
module wave_ram_array
   import apu_wave_pkg::*;
#(
   parameter int WAVE_BYTES = apu_wave_pkg::WAVE_BYTES
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [WAVE_AW-1:0]   wa,
   input  wave_byte_t           wd,
   input  logic [WAVE_AW-1:0]   ra0,
   output wave_byte_t           rd0,
   input  logic [WAVE_AW-1:0]   ra1,
   output wave_byte_t           rd1
);

   wave_byte_t mem [WAVE_BYTES];

   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   // Combinational reads see the old byte during a same-cycle write.
   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/wave_ram.sv
// Channel 3 wave RAM: CPU access gated by the playback window, sample fetch
// into byte_buf, and nibble selection toward the channel.
module wave_ram
   import apu_wave_pkg::*;
#(
   parameter int WAVE_BYTES = apu_wave_pkg::WAVE_BYTES
) (
   input  logic               cery_2mhz,
   input  logic               apu_reset,
   input  logic [3:0]         cpu_a,
   input  logic               cpu_wr,
   input  logic               cpu_rd,
   input  logic [7:0]         cpu_d_in,
   output logic [7:0]         cpu_d_out,
   input  logic               ch3_active,
   input  logic [3:0]         wave_a,
   input  logic               efar_q,
   input  logic               fetch,
   output logic [3:0]         wave_play_d
);

   logic [WIN_CNT_W-1:0] win_cnt;
   logic                 window_open;
   logic                 access_ok;
   logic [WAVE_AW-1:0]   access_a;
   logic                 array_we;
   wave_byte_t           cpu_rdata;
   wave_byte_t           wave_rdata;
   wave_byte_t           byte_buf;

   // While the channel plays, the CPU only reaches the byte being fetched.
   assign window_open = fetch || (win_cnt != '0);
   assign access_ok   = !ch3_active || window_open;
   assign access_a    = ch3_active ? wave_a : cpu_a;
   assign array_we    = cpu_wr && access_ok && !apu_reset;

   wave_ram_array #(
      .WAVE_BYTES (WAVE_BYTES)
   ) u_array (
      .clk (cery_2mhz),
      .we  (array_we),
      .wa  (access_a),
      .wd  (cpu_d_in),
      .ra0 (access_a),
      .rd0 (cpu_rdata),
      .ra1 (wave_a),
      .rd1 (wave_rdata)
   );

   always_ff @(posedge cery_2mhz) begin
      if (apu_reset || !ch3_active)
         win_cnt <= '0;
      else if (fetch)
         win_cnt <= WIN_LOAD;
      else if (win_cnt != '0)
         win_cnt <= win_cnt - WIN_CNT_W'(1);
   end

   always_ff @(posedge cery_2mhz) begin
      if (apu_reset)
         cpu_d_out <= WAVE_CLOSED_RD;
      else if (cpu_rd)
         cpu_d_out <= access_ok ? cpu_rdata : WAVE_CLOSED_RD;
   end

   // Stage 1: capture the fetched byte.
   always_ff @(posedge cery_2mhz) begin
      if (apu_reset)
         byte_buf <= '0;
      else if (fetch)
         byte_buf <= wave_rdata;
   end

   // Stage 2: select the nibble presented to channel 3.
   always_ff @(posedge cery_2mhz) begin
      if (apu_reset)
         wave_play_d <= '0;
      else
         wave_play_d <= efar_q ? byte_buf[3:0] : byte_buf[7:4];
   end

endmodule

// File: tb/tb_wave_ram.sv
// Directed self-checking bench for wave_ram: CPU access, playback latency,
// access window, address redirect and reset behaviour.
module tb_wave_ram;

   logic       clk = 1'b0;
   logic       apu_reset;
   logic [3:0] cpu_a;
   logic       cpu_wr;
   logic       cpu_rd;
   logic [7:0] cpu_d_in;
   logic [7:0] cpu_d_out;
   logic       ch3_active;
   logic [3:0] wave_a;
   logic       efar_q;
   logic       fetch;
   logic [3:0] wave_play_d;

   int checks = 0;
   int errors = 0;

   wave_ram dut (
      .cery_2mhz   (clk),
      .apu_reset   (apu_reset),
      .cpu_a       (cpu_a),
      .cpu_wr      (cpu_wr),
      .cpu_rd      (cpu_rd),
      .cpu_d_in    (cpu_d_in),
      .cpu_d_out   (cpu_d_out),
      .ch3_active  (ch3_active),
      .wave_a      (wave_a),
      .efar_q      (efar_q),
      .fetch       (fetch),
      .wave_play_d (wave_play_d)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      fetch  = 1'b0;
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
      ch3_active = 1'b0;
      cpu_a = a; cpu_d_in = d; cpu_wr = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      apu_reset = 1'b1;
      tick();
      apu_reset = 1'b0;
      checks++;
      if (cpu_d_out !== 8'hFF) begin
         errors++; $display("FAIL reset_cpu_d_out got %h want ff", cpu_d_out);
      end
      tick();
      checks++;
      if (wave_play_d !== 4'h0) begin
         errors++; $display("FAIL reset_wave_play got %h want 0", wave_play_d);
      end
   endtask

   task automatic test_idle_rw();
      cpu_write(4'd3, 8'hA5);
      cpu_a = 4'd3; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'hA5) begin
         errors++; $display("FAIL idle_read got %h want a5", cpu_d_out);
      end
      cpu_a = 4'd0;
      tick();
      checks++;
      if (cpu_d_out !== 8'hA5) begin
         errors++; $display("FAIL read_hold got %h want a5", cpu_d_out);
      end
      // Write and read together return the old byte.
      cpu_a = 4'd3; cpu_d_in = 8'h5A; cpu_wr = 1'b1; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'hA5) begin
         errors++; $display("FAIL wr_rd_old got %h want a5", cpu_d_out);
      end
      cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h5A) begin
         errors++; $display("FAIL wr_rd_new got %h want 5a", cpu_d_out);
      end
   endtask

   task automatic test_playback();
      cpu_write(4'd5, 8'h3C);
      wave_a = 4'd5; efar_q = 1'b0; fetch = 1'b1;
      tick();
      fetch = 1'b0;
      checks++;
      if (wave_play_d !== 4'h0) begin
         errors++; $display("FAIL play_latency got %h want 0", wave_play_d);
      end
      tick();
      checks++;
      if (wave_play_d !== 4'h3) begin
         errors++; $display("FAIL play_hi got %h want 3", wave_play_d);
      end
      efar_q = 1'b1;
      tick();
      checks++;
      if (wave_play_d !== 4'hC) begin
         errors++; $display("FAIL play_lo got %h want c", wave_play_d);
      end
   endtask

   task automatic test_fetch_idle();
      ch3_active = 1'b0; wave_a = 4'd3; efar_q = 1'b0; fetch = 1'b1;
      tick();
      fetch = 1'b0;
      tick();
      checks++;
      if (wave_play_d !== 4'h5) begin
         errors++; $display("FAIL fetch_idle got %h want 5", wave_play_d);
      end
   endtask

   task automatic test_window();
      cpu_write(4'd7, 8'h12);
      ch3_active = 1'b1; wave_a = 4'd7; cpu_a = 4'd0;
      fetch = 1'b1; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h12) begin
         errors++; $display("FAIL win_fetch_rd got %h want 12", cpu_d_out);
      end
      fetch = 1'b1;
      tick();
      fetch = 1'b0; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h12) begin
         errors++; $display("FAIL win_plus1_rd got %h want 12", cpu_d_out);
      end
      fetch = 1'b1;
      tick();
      idle();
      tick();
      tick();
      cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'hFF) begin
         errors++; $display("FAIL win_closed_rd got %h want ff", cpu_d_out);
      end
      cpu_d_in = 8'h99; cpu_wr = 1'b1;
      tick();
      idle();
      ch3_active = 1'b0; cpu_a = 4'd7; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h12) begin
         errors++; $display("FAIL win_closed_wr got %h want 12", cpu_d_out);
      end
   endtask

   task automatic test_redirect();
      cpu_write(4'd2, 8'h4B);
      cpu_write(4'd9, 8'h66);
      ch3_active = 1'b1; wave_a = 4'd2; cpu_a = 4'd9; efar_q = 1'b0;
      fetch = 1'b1; cpu_wr = 1'b1; cpu_d_in = 8'h77;
      tick();
      idle();
      tick();
      checks++;
      if (wave_play_d !== 4'h4) begin
         errors++; $display("FAIL redirect_buf_hi got %h want 4", wave_play_d);
      end
      ch3_active = 1'b0; efar_q = 1'b1;
      tick();
      checks++;
      if (wave_play_d !== 4'hB) begin
         errors++; $display("FAIL redirect_buf_lo got %h want b", wave_play_d);
      end
      cpu_a = 4'd2; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h77) begin
         errors++; $display("FAIL redirect_byte2 got %h want 77", cpu_d_out);
      end
      cpu_a = 4'd9; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h66) begin
         errors++; $display("FAIL redirect_byte9 got %h want 66", cpu_d_out);
      end
   endtask

   task automatic test_reset_mid();
      ch3_active = 1'b1; wave_a = 4'd5; efar_q = 1'b0; fetch = 1'b1;
      tick();
      idle();
      apu_reset = 1'b1; cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_d_in = 8'h00;
      fetch = 1'b1;
      tick();
      apu_reset = 1'b0;
      idle();
      checks++;
      if (cpu_d_out !== 8'hFF) begin
         errors++; $display("FAIL rst_mid_cpu_d_out got %h want ff", cpu_d_out);
      end
      checks++;
      if (wave_play_d !== 4'h0) begin
         errors++; $display("FAIL rst_mid_wave_play got %h want 0", wave_play_d);
      end
      tick();
      checks++;
      if (wave_play_d !== 4'h0) begin
         errors++; $display("FAIL rst_mid_byte_buf got %h want 0", wave_play_d);
      end
      cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'hFF) begin
         errors++; $display("FAIL rst_mid_win got %h want ff", cpu_d_out);
      end
      ch3_active = 1'b0; cpu_a = 4'd5; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h3C) begin
         errors++; $display("FAIL rst_mid_retain got %h want 3c", cpu_d_out);
      end
      cpu_a = 4'd7; cpu_rd = 1'b1;
      tick();
      idle();
      checks++;
      if (cpu_d_out !== 8'h12) begin
         errors++; $display("FAIL rst_mid_retain7 got %h want 12", cpu_d_out);
      end
   endtask

   initial begin
      apu_reset = 1'b0; cpu_a = '0; cpu_d_in = '0; ch3_active = 1'b0;
      wave_a = '0; efar_q = 1'b0;
      idle();
      #2;
      test_reset();
      test_idle_rw();
      test_playback();
      test_fetch_idle();
      test_window();
      test_redirect();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wave_ram.md
WAVE_RAM -- requirements
Module: wave_ram

Interface
REQ-001 The module SHALL expose parameter WAVE_BYTES, default 16, meaning the number of wave pattern bytes (FF30-FF3F).
REQ-002 The module SHALL expose port cery_2mhz  input  1  the only clock; all state updates on its rising edge.
REQ-003 The module SHALL expose port apu_reset  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL expose port cpu_a  input  4  CPU byte index within FF30-FF3F.
REQ-005 The module SHALL expose port cpu_wr  input  1  CPU write strobe, one cycle per access.
REQ-006 The module SHALL expose port cpu_rd  input  1  CPU read strobe, one cycle per access.
REQ-007 The module SHALL expose port cpu_d_in  input  8  CPU write data.
REQ-008 The module SHALL expose port cpu_d_out  output  8  CPU read data, registered.
REQ-009 The module SHALL expose port ch3_active  input  1  channel 3 playing.
REQ-010 The module SHALL expose port wave_a  input  4  byte index requested by channel 3.
REQ-011 The module SHALL expose port efar_q  input  1  nibble select: 0 = bits 7:4, 1 = bits 3:0.
REQ-012 The module SHALL expose port fetch  input  1  one-cycle sample fetch pulse from channel 3.
REQ-013 The module SHALL expose port wave_play_d  output  4  current sample nibble to channel 3, registered.

Function
REQ-014 Storage SHALL be 16 x 8 bits; writes synchronous, reads combinational from the array.
REQ-015 On fetch=1, the byte at wave_a SHALL be captured into byte_buf at the next edge.
REQ-016 wave_play_d SHALL equal byte_buf[7:4] when efar_q=0, byte_buf[3:0] when efar_q=1; registered, so it changes 1 cycle after byte_buf or efar_q changes.
REQ-017 Fetch-to-wave_play_d latency SHALL be 2 cycles.
REQ-018 With ch3_active=0, CPU accesses SHALL address byte cpu_a and always succeed.
REQ-019 With ch3_active=1, CPU accesses SHALL address byte wave_a, ignoring cpu_a.
REQ-020 With ch3_active=1, access SHALL succeed only while window_open = fetch OR win_cnt!=0; win_cnt is loaded with 1 on fetch and decrements to 0 otherwise (window = fetch cycle plus 1).
REQ-021 A failed write SHALL be dropped; a failed read SHALL return 8'hFF.
REQ-022 cpu_d_out SHALL be updated 1 cycle after cpu_rd and hold its value until the next cpu_rd.
REQ-023 Reads SHALL be read-before-write: a simultaneous fetch or cpu_rd on the byte being written SHALL return the old contents.
REQ-024 cpu_wr and cpu_rd together SHALL perform the write and return the old byte.
REQ-025 ch3_active falling SHALL clear win_cnt on the next edge; byte_buf and wave_play_d SHALL hold.
REQ-026 fetch while ch3_active=0 SHALL still load byte_buf (bench power-up reload).

Reset
REQ-027 apu_reset SHALL set byte_buf=0, wave_play_d=0, win_cnt=0 and cpu_d_out=8'hFF at the next edge.
REQ-028 apu_reset SHALL NOT modify the 16-byte array; its contents are retained across reset.
REQ-029 Strobes asserted in the reset cycle SHALL be ignored, including writes.

Structure
REQ-030 Package apu_wave_pkg SHALL hold WAVE_BYTES, typedefs wave_byte_t (8 bits) and wave_nib_t (4 bits), and constant WAVE_CLOSED_RD = 8'hFF.
REQ-031 The array SHALL be one sub-module, wave_ram_array (1 write port, 2 combinational read ports); window, mux and output registers stay in wave_ram.

Verification
REQ-032 Idle write/read: ch3_active=0, write 8'hA5 to index 3, cpu_rd index 3 -> cpu_d_out=8'hA5 one cycle later.
REQ-033 Playback: byte 5=8'h3C, fetch with wave_a=5, efar_q=0 -> wave_play_d=4'h3 at +2 cycles; efar_q->1 -> 4'hC one cycle later.
REQ-034 Window: ch3_active=1, wave_a=7 holding 8'h12; cpu_rd in fetch cycle -> 8'h12; cpu_rd 3 cycles after fetch -> 8'hFF; write 8'h99 outside window -> byte 7 unchanged.
REQ-035 Redirect: ch3_active=1, wave_a=2, cpu_a=9, write 8'h77 in fetch cycle -> byte 2=8'h77, byte 9 unchanged; byte_buf holds old byte 2.
REQ-036 Reset mid-play: array loaded, apu_reset pulse -> wave_play_d=0, cpu_d_out=8'hFF, win_cnt=0; subsequent reads return pre-reset array contents.
